// File: rtl/decode_issue_stage_pkg.sv
// Shared constants, field positions and decoded-instruction record for the decode/issue stage.
package decode_issue_stage_pkg;

    localparam logic [5:0] OP_RTYPE  = 6'd0;
    localparam logic [5:0] FUNCT_ADD = 6'd0;
    localparam logic [5:0] FUNCT_SUB = 6'd2;
    localparam logic [5:0] FUNCT_XOR = 6'd10;

    localparam int unsigned OP_MSB    = 31;
    localparam int unsigned OP_LSB    = 26;
    localparam int unsigned RS_MSB    = 25;
    localparam int unsigned RS_LSB    = 21;
    localparam int unsigned RT_MSB    = 20;
    localparam int unsigned RT_LSB    = 16;
    localparam int unsigned RD_MSB    = 15;
    localparam int unsigned RD_LSB    = 11;
    localparam int unsigned FUNCT_MSB = 5;
    localparam int unsigned FUNCT_LSB = 0;
    localparam int unsigned IMM_MSB   = 15;
    localparam int unsigned IMM_LSB   = 0;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  regnum0;
        logic [4:0]  regnum1;
        logic [4:0]  regnum2;
        logic        we0;
        logic        alusrc;
        logic        illegal;
        logic [31:0] imm;
    } dec_t;

    // Full decode of one instruction word; regnums at or above nregs flag it illegal
    // and suppress the destination write.
    function automatic dec_t decode_inst(input logic [31:0] inst, input int unsigned nregs);
        dec_t       d;
        logic       rtype;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
        rtype     = (inst[OP_MSB:OP_LSB] == OP_RTYPE);
        rs        = inst[RS_MSB:RS_LSB];
        rt        = inst[RT_MSB:RT_LSB];
        rd        = inst[RD_MSB:RD_LSB];
        d.opcode  = inst[OP_MSB:OP_LSB];
        d.funct   = inst[FUNCT_MSB:FUNCT_LSB];
        d.regnum0 = rs;
        d.regnum1 = rtype ? rt : 5'd0;
        d.regnum2 = rtype ? rd : rt;
        d.alusrc  = !rtype;
        d.imm     = {{16{inst[IMM_MSB]}}, inst[IMM_MSB:IMM_LSB]};
        d.illegal = (32'(d.regnum0) >= nregs) || (32'(d.regnum1) >= nregs) ||
                    (32'(d.regnum2) >= nregs);
        d.we0     = (d.regnum2 != 5'd0) && !d.illegal;
        return d;
    endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write scoreboard with writeback bypass on both read ports.
module reg_scoreboard
    import decode_issue_stage_pkg::*;
#(
    parameter int unsigned NREGS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       set_en,
    input  logic [4:0] set_reg,
    input  logic       clr_en,
    input  logic [4:0] clr_reg,
    input  logic [4:0] rd_reg0,
    input  logic [4:0] rd_reg1,
    output logic       rd_pend0,
    output logic       rd_pend1
);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic [NREGS-1:0] set_mask;
    logic [NREGS-1:0] clr_mask;
    logic [NREGS-1:0] pend_eff;

    // Masks start at index 1 so r0 and out-of-range numbers never touch the vector;
    // the set is applied after the clear so a same-cycle set wins.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        rd_pend0 = 1'b0;
        rd_pend1 = 1'b0;
        for (int unsigned i = 1; i < NREGS; i++) begin
            if (set_en && (32'(set_reg) == i)) set_mask[i] = 1'b1;
            if (clr_en && (32'(clr_reg) == i)) clr_mask[i] = 1'b1;
        end
        pend_eff = pend_q & ~clr_mask;
        pend_d   = pend_eff | set_mask;
        for (int unsigned i = 1; i < NREGS; i++) begin
            if (32'(rd_reg0) == i) rd_pend0 = pend_eff[i];
            if (32'(rd_reg1) == i) rd_pend1 = pend_eff[i];
        end
    end

    // Pending vector register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: one-entry IF/ID register, registered decode, RAW stall and issue handshake.
module decode_issue_stage
    import decode_issue_stage_pkg::*;
#(
    parameter int unsigned NREGS   = 16,
    parameter int unsigned STALL_W = 16
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               inst_valid,
    input  logic [31:0]        INST,
    output logic               inst_ready,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [5:0]         opcode,
    output logic [5:0]         funct,
    output logic [4:0]         REGNUM0,
    output logic [4:0]         REGNUM1,
    output logic [4:0]         REGNUM2,
    output logic               WE0,
    output logic               ALUsrc,
    output logic [31:0]        imm_i,
    output logic               illegal,
    input  logic               wb_valid,
    input  logic [4:0]         wb_regnum,
    output logic [STALL_W-1:0] stall_cnt
);

    dec_t               dec_q;
    dec_t               dec_d;
    logic               held_valid_q;
    logic               held_valid_d;
    logic [STALL_W-1:0] stall_cnt_q;
    logic [STALL_W-1:0] stall_cnt_d;
    logic               pend_a;
    logic               pend_b;
    logic               hazard;
    logic               issue;
    logic               capture;

    reg_scoreboard #(.NREGS(NREGS)) u_scoreboard (
        .clk      (CLK),
        .rst_n    (RST_N),
        .set_en   (issue && dec_q.we0),
        .set_reg  (dec_q.regnum2),
        .clr_en   (wb_valid),
        .clr_reg  (wb_regnum),
        .rd_reg0  (dec_q.regnum0),
        .rd_reg1  (dec_q.regnum1),
        .rd_pend0 (pend_a),
        .rd_pend1 (pend_b)
    );

    assign hazard = pend_a || ((dec_q.opcode == OP_RTYPE) && pend_b);

    // Handshake, capture/issue decisions and next-state for the held entry and stall counter.
    always_comb begin
        out_valid    = held_valid_q && !hazard && !flush;
        issue        = out_valid && out_ready;
        inst_ready   = !held_valid_q || issue;
        capture      = inst_valid && inst_ready && !flush;
        held_valid_d = held_valid_q;
        dec_d        = dec_q;
        stall_cnt_d  = stall_cnt_q;
        if (flush)        held_valid_d = 1'b0;
        else if (capture) held_valid_d = 1'b1;
        else if (issue)   held_valid_d = 1'b0;
        if (capture) dec_d = decode_inst(INST, NREGS);
        if (held_valid_q && hazard && !flush && (stall_cnt_q != '1))
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end

    // IF/ID register, decoded fields and stall counter.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            held_valid_q <= 1'b0;
            dec_q        <= '0;
            stall_cnt_q  <= '0;
        end else begin
            held_valid_q <= held_valid_d;
            dec_q        <= dec_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign opcode    = dec_q.opcode;
    assign funct     = dec_q.funct;
    assign REGNUM0   = dec_q.regnum0;
    assign REGNUM1   = dec_q.regnum1;
    assign REGNUM2   = dec_q.regnum2;
    assign WE0       = dec_q.we0;
    assign ALUsrc    = dec_q.alusrc;
    assign imm_i     = dec_q.imm;
    assign illegal   = dec_q.illegal;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Directed + randomized bench for decode_issue_stage against a cycle-level reference model.
module tb_decode_issue_stage;

    localparam int unsigned NR  = 16;
    localparam int unsigned SW  = 4;
    localparam int unsigned SAT = (1 << SW) - 1;

    logic          CLK;
    logic          RST_N;
    logic          inst_valid;
    logic [31:0]   INST;
    logic          inst_ready;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [5:0]    opcode;
    logic [5:0]    funct;
    logic [4:0]    REGNUM0;
    logic [4:0]    REGNUM1;
    logic [4:0]    REGNUM2;
    logic          WE0;
    logic          ALUsrc;
    logic [31:0]   imm_i;
    logic          illegal;
    logic          wb_valid;
    logic [4:0]    wb_regnum;
    logic [SW-1:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit          m_held;
    logic [31:0] m_inst;
    bit          m_pend[32];
    int unsigned m_stall;

    decode_issue_stage #(.NREGS(NR), .STALL_W(SW)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .inst_valid (inst_valid),
        .INST       (INST),
        .inst_ready (inst_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .opcode     (opcode),
        .funct      (funct),
        .REGNUM0    (REGNUM0),
        .REGNUM1    (REGNUM1),
        .REGNUM2    (REGNUM2),
        .WE0        (WE0),
        .ALUsrc     (ALUsrc),
        .imm_i      (imm_i),
        .illegal    (illegal),
        .wb_valid   (wb_valid),
        .wb_regnum  (wb_regnum),
        .stall_cnt  (stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rtype(input int unsigned rd, input int unsigned rs,
                                          input int unsigned rt, input int unsigned fn);
        return (rs << 21) + (rt << 16) + (rd << 11) + fn;
    endfunction

    function automatic logic [31:0] itype(input int unsigned op, input int unsigned rt,
                                          input int unsigned rs, input int unsigned imm);
        return (op << 26) + (rs << 21) + (rt << 16) + (imm & 32'hFFFF);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_held  = 1'b0;
        m_inst  = '0;
        m_stall = 0;
        for (int r = 0; r < 32; r++) m_pend[r] = 1'b0;
    endtask

    // One clock: drive at negedge, compare #1 later, advance the model at posedge.
    task automatic cycle(input bit iv, input logic [31:0] ins, input bit fl, input bit ordy,
                         input bit wbv, input logic [4:0] wbr, output bit ov);
        bit          pe[32];
        int unsigned op, rs, rt, rd, r1, r2, imm;
        bit          ill, we, haz, e_ov, e_ir, iss, cap;
        @(negedge CLK);
        inst_valid = iv;
        INST       = ins;
        flush      = fl;
        out_ready  = ordy;
        wb_valid   = wbv;
        wb_regnum  = wbr;
        #1;
        op  = m_inst >> 26;
        rs  = (m_inst >> 21) % 32;
        rt  = (m_inst >> 16) % 32;
        rd  = (m_inst >> 11) % 32;
        r1  = (op == 0) ? rt : 0;
        r2  = (op == 0) ? rd : rt;
        imm = m_inst % 65536;
        if (imm >= 32768) imm = imm + 32'hFFFF0000;
        ill = (rs >= NR) || (r1 >= NR) || (r2 >= NR);
        we  = (r2 != 0) && !ill;
        for (int r = 0; r < 32; r++) pe[r] = m_pend[r] && !(wbv && (32'(wbr) == r));
        haz  = m_held && (pe[rs] || (op == 0 && pe[rt]));
        e_ov = m_held && !haz && !fl;
        iss  = e_ov && ordy;
        e_ir = !m_held || iss;
        cap  = iv && e_ir && !fl;
        chk("out_valid",  32'(out_valid),  32'(e_ov));
        chk("inst_ready", 32'(inst_ready), 32'(e_ir));
        chk("opcode",     32'(opcode),     op);
        chk("funct",      32'(funct),      m_inst % 64);
        chk("REGNUM0",    32'(REGNUM0),    rs);
        chk("REGNUM1",    32'(REGNUM1),    r1);
        chk("REGNUM2",    32'(REGNUM2),    r2);
        chk("WE0",        32'(WE0),        32'(we));
        chk("ALUsrc",     32'(ALUsrc),     32'(op != 0));
        chk("imm_i",      imm_i,           imm);
        chk("illegal",    32'(illegal),    32'(ill));
        chk("stall_cnt",  32'(stall_cnt),  m_stall);
        ov = out_valid;
        @(posedge CLK);
        if (wbv && wbr != 0 && 32'(wbr) < NR) m_pend[wbr] = 1'b0;
        if (iss && we) m_pend[r2] = 1'b1;
        if (m_held && haz && !fl && m_stall < SAT) m_stall++;
        if (fl) m_held = 1'b0;
        else if (cap) begin
            m_held = 1'b1;
            m_inst = ins;
        end else if (iss) m_held = 1'b0;
        #1;
    endtask

    initial begin : stim
        bit          ov;
        logic [31:0] ADD_R3, ADDI_R5, SUB_R4, XOR_R7, ADD_R9, ADDI_R6, ADD_R8;
        logic [31:0] ins;
        int unsigned op;
        ADD_R3  = rtype(3, 1, 2, 0);
        ADDI_R5 = itype(8, 5, 0, 32'hFFFF);
        SUB_R4  = rtype(4, 3, 1, 2);
        XOR_R7  = rtype(7, 1, 2, 10);
        ADD_R9  = rtype(9, 1, 2, 0);
        ADDI_R6 = itype(8, 6, 0, 1);
        ADD_R8  = rtype(8, 6, 0, 0);

        RST_N = 1'b1; inst_valid = 0; INST = '0; flush = 0; out_ready = 0;
        wb_valid = 0; wb_regnum = '0;
        model_reset();
        #2 RST_N = 1'b0;
        #1;
        chk("rst_out_valid",  32'(out_valid),  0);
        chk("rst_inst_ready", 32'(inst_ready), 1);
        chk("rst_stall_cnt",  32'(stall_cnt),  0);
        chk("rst_regnum2",    32'(REGNUM2),    0);
        chk("rst_imm",        imm_i,           0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;

        // 1: add r3,r1,r2
        chk("t1_encoding", ADD_R3, 32'h00221800);
        cycle(1, ADD_R3, 0, 1, 0, 0, ov);
        chk("t1_regnum2", 32'(REGNUM2), 3);
        chk("t1_we0",     32'(WE0),     1);
        chk("t1_alusrc",  32'(ALUsrc),  0);
        // 2: addi r5,r0,-1 captured while add issues
        cycle(1, ADDI_R5, 0, 1, 0, 0, ov);
        chk("t1_issue",   32'(ov),      1);
        chk("t2_imm",     imm_i,        32'hFFFFFFFF);
        chk("t2_alusrc",  32'(ALUsrc),  1);
        chk("t2_regnum2", 32'(REGNUM2), 5);
        chk("t2_regnum1", 32'(REGNUM1), 0);

        // 3: write r3, then read r3 -> stall until writeback bypass
        cycle(1, ADD_R3, 0, 1, 0, 0, ov);
        cycle(1, SUB_R4, 0, 1, 0, 0, ov);
        for (int k = 1; k <= 3; k++) begin
            cycle(0, '0, 0, 1, 0, 0, ov);
            chk("t3_stalled", 32'(ov), 0);
            chk("t3_stall_cnt", 32'(stall_cnt), k);
        end
        cycle(0, '0, 0, 1, 1, 3, ov);
        chk("t3_bypass_issue", 32'(ov), 1);

        // 4: backpressure holds outputs stable, single issue on release
        cycle(1, XOR_R7, 0, 0, 0, 0, ov);
        for (int k = 0; k < 4; k++) begin
            cycle(1, ADD_R9, 0, 0, 0, 0, ov);
            chk("t4_hold_valid", 32'(ov),      1);
            chk("t4_hold_rd",    32'(REGNUM2), 7);
            chk("t4_hold_funct", 32'(funct),   10);
        end
        cycle(0, '0, 0, 1, 0, 0, ov);
        chk("t4_release", 32'(ov), 1);
        cycle(0, '0, 0, 1, 0, 0, ov);
        chk("t4_no_dup", 32'(ov), 0);

        // 5: issue writing r6 with same-cycle writeback of r6 -> stays pending
        cycle(1, ADDI_R6, 0, 1, 0, 0, ov);
        cycle(1, ADD_R8, 0, 1, 1, 6, ov);
        chk("t5_issue", 32'(ov), 1);
        cycle(0, '0, 0, 1, 0, 0, ov);
        chk("t5_set_wins", 32'(ov), 0);
        cycle(0, '0, 0, 1, 1, 6, ov);
        chk("t5_cleared", 32'(ov), 1);

        // 6: flush while stalled keeps pending; async reset clears everything
        cycle(1, ADD_R3, 0, 1, 0, 0, ov);
        cycle(1, SUB_R4, 0, 1, 0, 0, ov);
        cycle(0, '0, 0, 1, 0, 0, ov);
        chk("t6_stalled", 32'(ov), 0);
        cycle(0, '0, 1, 1, 0, 0, ov);
        chk("t6_flush_no_issue", 32'(ov), 0);
        cycle(1, SUB_R4, 0, 1, 0, 0, ov);
        cycle(0, '0, 0, 1, 0, 0, ov);
        chk("t6_pending_kept", 32'(ov), 0);
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1;
        chk("t6_rst_stall_cnt",  32'(stall_cnt),  0);
        chk("t6_rst_out_valid",  32'(out_valid),  0);
        chk("t6_rst_inst_ready", 32'(inst_ready), 1);
        model_reset();
        @(negedge CLK);
        RST_N = 1'b1;
        cycle(1, SUB_R4, 0, 1, 0, 0, ov);
        cycle(0, '0, 0, 1, 0, 0, ov);
        chk("t6_pending_cleared", 32'(ov), 1);

        // stall counter saturation
        cycle(1, itype(8, 9, 0, 5), 0, 1, 0, 0, ov);
        cycle(1, rtype(10, 9, 9, 0), 0, 1, 0, 0, ov);
        for (int k = 0; k < 20; k++) cycle(0, '0, 0, 1, 0, 0, ov);
        chk("sat_stall_cnt", 32'(stall_cnt), SAT);
        cycle(0, '0, 0, 1, 1, 9, ov);
        chk("sat_release", 32'(ov), 1);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                0:       op = $urandom_range(1, 63);
                1:       op = 8;
                default: op = 0;
            endcase
            if (op == 0)
                ins = rtype($urandom_range(0, 17), $urandom_range(0, 17),
                            $urandom_range(0, 17), $urandom_range(0, 63));
            else
                ins = itype(op, $urandom_range(0, 17), $urandom_range(0, 17), $urandom);
            cycle($urandom_range(0, 99) < 70, ins, $urandom_range(0, 99) < 4,
                  $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 35,
                  5'($urandom_range(0, 19)), ov);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
